// File: rtl/move_ctrl_pkg.sv
// Shared types and constants for the interact-path move controller.
// Map geometry, FSM encoding and the direction-to-target helper live here.
package move_ctrl_pkg;

  localparam int unsigned MAP_DIM = 16;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned TILE_W  = 16;
  localparam int unsigned KEY_W   = 4;
  localparam int unsigned ADDR_W  = 2 * COORD_W;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [TILE_W-1:0]  tile_t;
  typedef logic [KEY_W-1:0]   key_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  localparam coord_t COORD_MIN = coord_t'(0);
  localparam coord_t COORD_MAX = coord_t'(MAP_DIM - 1);
  localparam coord_t COORD_ONE = coord_t'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWait,
    StCommit
  } state_e;

  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
  } target_t;

  // Map RAM is row-major: high nibble is y, low nibble is x.
  function automatic addr_t tile_addr(coord_t x, coord_t y);
    return {y, x};
  endfunction

  // Priority up > down > left > right; a step off the map edge is not valid.
  function automatic target_t step_target(logic up, logic down, logic left, logic right,
                                          coord_t x, coord_t y);
    target_t t;
    t.valid = 1'b0;
    t.x     = x;
    t.y     = y;
    if (up) begin
      t.valid = (y != COORD_MIN);
      t.y     = y - COORD_ONE;
    end else if (down) begin
      t.valid = (y != COORD_MAX);
      t.y     = y + COORD_ONE;
    end else if (left) begin
      t.valid = (x != COORD_MIN);
      t.x     = x - COORD_ONE;
    end else if (right) begin
      t.valid = (x != COORD_MAX);
      t.x     = x + COORD_ONE;
    end
    return t;
  endfunction

endpackage

// File: rtl/move_ctrl_if.sv
// Map RAM port plus the operand/result bundle exchanged with mux_tiles.
// master = move_ctrl side, slave = RAM / mux_tiles side.
interface move_ctrl_if;
  import move_ctrl_pkg::*;

  addr_t  map_addr;
  logic   map_re;
  tile_t  map_rdata;
  logic   map_we;
  tile_t  map_wdata;

  tile_t  mt_tile_id;
  coord_t mt_pos_x;
  coord_t mt_pos_y;
  coord_t mt_player_x;
  coord_t mt_player_y;
  key_t   mt_key_num;

  coord_t mt_goto_x;
  coord_t mt_goto_y;
  key_t   mt_key_num_out;
  tile_t  mt_new_tile_id;

  modport master (
    output map_addr, map_re, map_we, map_wdata,
    output mt_tile_id, mt_pos_x, mt_pos_y, mt_player_x, mt_player_y, mt_key_num,
    input  map_rdata,
    input  mt_goto_x, mt_goto_y, mt_key_num_out, mt_new_tile_id
  );

  modport slave (
    input  map_addr, map_re, map_we, map_wdata,
    input  mt_tile_id, mt_pos_x, mt_pos_y, mt_player_x, mt_player_y, mt_key_num,
    output map_rdata,
    output mt_goto_x, mt_goto_y, mt_key_num_out, mt_new_tile_id
  );

endinterface

// File: rtl/move_ctrl.sv
// Turns a one-cycle direction pulse into a map read, hands the tile to mux_tiles
// and commits the resolved player position, key count and tile write-back.
module move_ctrl
  import move_ctrl_pkg::*;
#(
  parameter coord_t      START_X    = 4'd1,
  parameter coord_t      START_Y    = 4'd1,
  parameter int unsigned RD_LATENCY = 1,
  parameter key_t        KEY_MAX    = 4'd15
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_up,
  input  logic   req_down,
  input  logic   req_left,
  input  logic   req_right,
  output logic   busy,
  output logic   move_done,
  move_ctrl_if.master bus,
  output coord_t player_x,
  output coord_t player_y,
  output key_t   key_num
);

  state_e     state_q, state_d;
  coord_t     tgt_x_q, tgt_x_d;
  coord_t     tgt_y_q, tgt_y_d;
  tile_t      tile_q, tile_d;
  logic [1:0] wait_q, wait_d;
  coord_t     player_x_q, player_x_d;
  coord_t     player_y_q, player_y_d;
  key_t       key_q, key_d;

  target_t    tgt;

  assign tgt = step_target(req_up, req_down, req_left, req_right, player_x_q, player_y_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      tile_q     <= '0;
      wait_q     <= '0;
      player_x_q <= START_X;
      player_y_q <= START_Y;
      key_q      <= '0;
    end else begin
      state_q    <= state_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      tile_q     <= tile_d;
      wait_q     <= wait_d;
      player_x_q <= player_x_d;
      player_y_q <= player_y_d;
      key_q      <= key_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tgt_x_d       = tgt_x_q;
    tgt_y_d       = tgt_y_q;
    tile_d        = tile_q;
    wait_d        = wait_q;
    player_x_d    = player_x_q;
    player_y_d    = player_y_q;
    key_d         = key_q;
    busy          = 1'b1;
    move_done     = 1'b0;
    bus.map_re    = 1'b0;
    bus.map_we    = 1'b0;
    bus.map_addr  = '0;
    bus.map_wdata = '0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        // Requests are only sampled here, so pulses during a move are dropped.
        if (tgt.valid) begin
          tgt_x_d = tgt.x;
          tgt_y_d = tgt.y;
          state_d = StRead;
        end
      end

      StRead: begin
        bus.map_re   = 1'b1;
        bus.map_addr = tile_addr(tgt_x_q, tgt_y_q);
        wait_d       = 2'(RD_LATENCY - 1);
        state_d      = StWait;
      end

      StWait: begin
        if (wait_q == 2'd0) begin
          tile_d  = bus.map_rdata;
          state_d = StCommit;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end

      StCommit: begin
        player_x_d = bus.mt_goto_x;
        player_y_d = bus.mt_goto_y;
        // Saturate instead of letting the 4-bit count wrap past KEY_MAX.
        if ((key_q == KEY_MAX) && (bus.mt_key_num_out != key_q)) begin
          key_d = KEY_MAX;
        end else begin
          key_d = bus.mt_key_num_out;
        end
        if (bus.mt_new_tile_id != tile_q) begin
          bus.map_we    = 1'b1;
          bus.map_addr  = tile_addr(tgt_x_q, tgt_y_q);
          bus.map_wdata = bus.mt_new_tile_id;
        end
        move_done = 1'b1;
        state_d   = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // mux_tiles sees only registered values, never the raw RAM output.
  assign bus.mt_tile_id  = tile_q;
  assign bus.mt_pos_x    = tgt_x_q;
  assign bus.mt_pos_y    = tgt_y_q;
  assign bus.mt_player_x = player_x_q;
  assign bus.mt_player_y = player_y_q;
  assign bus.mt_key_num  = key_q;

  assign player_x = player_x_q;
  assign player_y = player_y_q;
  assign key_num  = key_q;

  a_re_we_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.map_re && bus.map_we));

  a_done_not_busy_next: assert property (@(posedge clk) disable iff (!rst_n)
    move_done |=> !busy);

endmodule

// File: tb/tb_move_ctrl.sv
// Bench: two move_ctrl instances (read latency 1 and 3) share stimulus, each with a
// map RAM and mux_tiles model; a transaction-level reference predicts every move.
module tb_move_ctrl;
  import move_ctrl_pkg::*;

  localparam tile_t       T_GROUND = 16'h0000;
  localparam tile_t       T_WALL   = 16'h0001;
  localparam tile_t       T_KEY    = 16'h0002;
  localparam tile_t       T_DOOR   = 16'h0003;
  localparam int unsigned LAT0     = 1;
  localparam int unsigned LAT1     = 3;

  typedef struct packed {
    coord_t gx;
    coord_t gy;
    key_t   kout;
    tile_t  nt;
  } mux_res_t;

  // Behavioural mux_tiles: walls block, keys are picked up, doors cost a key.
  function automatic mux_res_t mux_fn(tile_t t, coord_t tx, coord_t ty, coord_t px,
                                      coord_t py, key_t k);
    mux_res_t r;
    r.gx = tx; r.gy = ty; r.kout = k; r.nt = t;
    case (t)
      T_WALL: begin r.gx = px; r.gy = py; end
      T_KEY:  begin r.kout = k + 4'd1; r.nt = T_GROUND; end
      T_DOOR: begin
        if (k == 4'd0) begin r.gx = px; r.gy = py; end
        else begin r.kout = k - 4'd1; r.nt = T_GROUND; end
      end
      default: ;
    endcase
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic req_up, req_down, req_left, req_right;

  logic   busy_v[2], done_v[2];
  coord_t px_v[2], py_v[2];
  key_t   key_v[2];

  move_ctrl_if ifc0();
  move_ctrl_if ifc1();

  move_ctrl #(.START_X(4'd1), .START_Y(4'd1), .RD_LATENCY(LAT0), .KEY_MAX(4'd15)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_up(req_up), .req_down(req_down), .req_left(req_left),
    .req_right(req_right), .busy(busy_v[0]), .move_done(done_v[0]), .bus(ifc0.master),
    .player_x(px_v[0]), .player_y(py_v[0]), .key_num(key_v[0])
  );

  move_ctrl #(.START_X(4'd1), .START_Y(4'd1), .RD_LATENCY(LAT1), .KEY_MAX(4'd15)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_up(req_up), .req_down(req_down), .req_left(req_left),
    .req_right(req_right), .busy(busy_v[1]), .move_done(done_v[1]), .bus(ifc1.master),
    .player_x(px_v[1]), .player_y(py_v[1]), .key_num(key_v[1])
  );

  always #5 clk = ~clk;

  logic  re_v[2], we_v[2];
  addr_t addr_v[2];
  tile_t wdata_v[2], mt_tile_v[2];
  coord_t mt_posx_v[2];
  assign re_v[0] = ifc0.map_re;       assign re_v[1] = ifc1.map_re;
  assign we_v[0] = ifc0.map_we;       assign we_v[1] = ifc1.map_we;
  assign addr_v[0] = ifc0.map_addr;   assign addr_v[1] = ifc1.map_addr;
  assign wdata_v[0] = ifc0.map_wdata; assign wdata_v[1] = ifc1.map_wdata;
  assign mt_tile_v[0] = ifc0.mt_tile_id; assign mt_tile_v[1] = ifc1.mt_tile_id;
  assign mt_posx_v[0] = ifc0.mt_pos_x;   assign mt_posx_v[1] = ifc1.mt_pos_x;

  // Map RAM: one array, preload port plus both DUT write ports; per-lane read pipes.
  tile_t mem[256];
  logic  pl_we;
  addr_t pl_addr;
  tile_t pl_data;
  tile_t pipe0;
  tile_t pipe1[3];

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (ifc0.map_we) mem[ifc0.map_addr] <= ifc0.map_wdata;
    if (ifc1.map_we) mem[ifc1.map_addr] <= ifc1.map_wdata;
    pipe0    <= ifc0.map_re ? mem[ifc0.map_addr] : 16'hdead;
    pipe1[0] <= ifc1.map_re ? mem[ifc1.map_addr] : 16'hdead;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign ifc0.map_rdata = pipe0;
  assign ifc1.map_rdata = pipe1[2];

  mux_res_t mres0, mres1;
  always_comb mres0 = mux_fn(ifc0.mt_tile_id, ifc0.mt_pos_x, ifc0.mt_pos_y,
                             ifc0.mt_player_x, ifc0.mt_player_y, ifc0.mt_key_num);
  always_comb mres1 = mux_fn(ifc1.mt_tile_id, ifc1.mt_pos_x, ifc1.mt_pos_y,
                             ifc1.mt_player_x, ifc1.mt_player_y, ifc1.mt_key_num);
  assign ifc0.mt_goto_x = mres0.gx;  assign ifc0.mt_goto_y = mres0.gy;
  assign ifc0.mt_key_num_out = mres0.kout;  assign ifc0.mt_new_tile_id = mres0.nt;
  assign ifc1.mt_goto_x = mres1.gx;  assign ifc1.mt_goto_y = mres1.gy;
  assign ifc1.mt_key_num_out = mres1.kout;  assign ifc1.mt_new_tile_id = mres1.nt;

  // Event monitor, sampled on the falling edge.
  int unsigned cyc = 0;
  int unsigned re_cnt[2]   = '{default: 0};
  int unsigned re_cyc[2]   = '{default: 0};
  int unsigned we_cnt[2]   = '{default: 0};
  int unsigned we_cyc[2]   = '{default: 0};
  int unsigned done_cnt[2] = '{default: 0};
  int unsigned done_cyc[2] = '{default: 0};
  int unsigned busy_cnt[2] = '{default: 0};
  int unsigned excl[2]     = '{default: 0};
  addr_t re_addr[2], we_addr[2];
  tile_t we_data[2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (re_v[l]) begin
        re_cnt[l] <= re_cnt[l] + 1; re_cyc[l] <= cyc; re_addr[l] <= addr_v[l];
      end
      if (we_v[l]) begin
        we_cnt[l] <= we_cnt[l] + 1; we_cyc[l] <= cyc;
        we_addr[l] <= addr_v[l]; we_data[l] <= wdata_v[l];
      end
      if (done_v[l]) begin done_cnt[l] <= done_cnt[l] + 1; done_cyc[l] <= cyc; end
      if (busy_v[l]) busy_cnt[l] <= busy_cnt[l] + 1;
      if (re_v[l] && we_v[l]) excl[l] <= excl[l] + 1;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model state.
  tile_t  ref_map[256];
  coord_t m_px = 4'd1;
  coord_t m_py = 4'd1;
  key_t   m_key = 4'd0;

  task automatic poke(input addr_t a, input tile_t d);
    ref_map[a] = d;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic do_move(input logic u, input logic dn, input logic lf, input logic rt);
    coord_t tx, ty;
    logic ok, ew, got;
    tile_t t;
    mux_res_t m;
    key_t ek;
    int unsigned n, lat;
    int unsigned s_re[2], s_we[2], s_done[2], s_busy[2];
    ok = 1'b1; tx = m_px; ty = m_py;
    if (u) begin ok = (m_py != 4'd0); ty = m_py - 4'd1; end
    else if (dn) begin ok = (m_py != 4'd15); ty = m_py + 4'd1; end
    else if (lf) begin ok = (m_px != 4'd0); tx = m_px - 4'd1; end
    else if (rt) begin ok = (m_px != 4'd15); tx = m_px + 4'd1; end
    else ok = 1'b0;
    for (int l = 0; l < 2; l++) begin
      s_re[l] = re_cnt[l]; s_we[l] = we_cnt[l]; s_done[l] = done_cnt[l]; s_busy[l] = busy_cnt[l];
    end
    req_up = u; req_down = dn; req_left = lf; req_right = rt;
    n = cyc;
    tick();
    req_up = 1'b0; req_down = 1'b0; req_left = 1'b0; req_right = 1'b0;
    if (ok) begin
      t  = ref_map[{ty, tx}];
      m  = mux_fn(t, tx, ty, m_px, m_py, m_key);
      ek = ((m_key == 4'd15) && (m.kout != m_key)) ? 4'd15 : m.kout;
      ew = (m.nt != t);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        tick();
        got = (done_cnt[0] != s_done[0]) && (done_cnt[1] != s_done[1]);
      end
      tick();
      check_eq("move_timeout", 32'(got), 32'd1);
      for (int l = 0; l < 2; l++) begin
        lat = (l == 0) ? LAT0 : LAT1;
        check_eq($sformatf("L%0d_re_count", l), re_cnt[l] - s_re[l], 32'd1);
        check_eq($sformatf("L%0d_re_addr", l), 32'(re_addr[l]), 32'({ty, tx}));
        check_eq($sformatf("L%0d_re_cycle", l), re_cyc[l], n + 1);
        check_eq($sformatf("L%0d_done_count", l), done_cnt[l] - s_done[l], 32'd1);
        check_eq($sformatf("L%0d_done_cycle", l), done_cyc[l], n + 2 + lat);
        check_eq($sformatf("L%0d_we_count", l), we_cnt[l] - s_we[l], 32'(ew));
        if (ew) begin
          check_eq($sformatf("L%0d_we_addr", l), 32'(we_addr[l]), 32'({ty, tx}));
          check_eq($sformatf("L%0d_we_data", l), 32'(we_data[l]), 32'(m.nt));
          check_eq($sformatf("L%0d_we_cycle", l), we_cyc[l], n + 2 + lat);
        end
        check_eq($sformatf("L%0d_player_x", l), 32'(px_v[l]), 32'(m.gx));
        check_eq($sformatf("L%0d_player_y", l), 32'(py_v[l]), 32'(m.gy));
        check_eq($sformatf("L%0d_key_num", l), 32'(key_v[l]), 32'(ek));
      end
      m_px = m.gx; m_py = m.gy; m_key = ek;
      if (ew) ref_map[{ty, tx}] = m.nt;
    end else begin
      repeat (6) tick();
      for (int l = 0; l < 2; l++) begin
        check_eq($sformatf("L%0d_drop_re", l), re_cnt[l] - s_re[l], 32'd0);
        check_eq($sformatf("L%0d_drop_done", l), done_cnt[l] - s_done[l], 32'd0);
        check_eq($sformatf("L%0d_drop_busy", l), busy_cnt[l] - s_busy[l], 32'd0);
        check_eq($sformatf("L%0d_drop_pos", l), 32'({py_v[l], px_v[l]}), 32'({m_py, m_px}));
        check_eq($sformatf("L%0d_drop_key", l), 32'(key_v[l]), 32'(m_key));
      end
    end
  endtask

  initial begin
    int unsigned s_re[2], s_we[2], s_done[2];
    int unsigned r;
    tile_t t;
    rst_n = 1'b0;
    req_up = 1'b0; req_down = 1'b0; req_left = 1'b0; req_right = 1'b0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    for (int a = 0; a < 256; a++) poke(addr_t'(a), T_GROUND);

    // Reset state.
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("L%0d_rst_busy", l), 32'(busy_v[l]), 32'd0);
      check_eq($sformatf("L%0d_rst_done", l), 32'(done_v[l]), 32'd0);
      check_eq($sformatf("L%0d_rst_re_we", l), 32'({re_v[l], we_v[l]}), 32'd0);
      check_eq($sformatf("L%0d_rst_addr", l), 32'(addr_v[l]), 32'd0);
      check_eq($sformatf("L%0d_rst_wdata", l), 32'(wdata_v[l]), 32'd0);
      check_eq($sformatf("L%0d_rst_pos", l), 32'({py_v[l], px_v[l]}), 32'h11);
      check_eq($sformatf("L%0d_rst_key", l), 32'(key_v[l]), 32'd0);
      check_eq($sformatf("L%0d_rst_mt_tile", l), 32'(mt_tile_v[l]), 32'd0);
    end

    poke(8'h01, T_WALL);
    poke(8'h21, T_KEY);
    for (int x = 3; x < 16; x++) poke(addr_t'({4'd1, 4'(x)}), T_KEY);
    poke(8'h2f, T_KEY);
    poke(8'h3f, T_KEY);
    rst_n = 1'b1;
    tick();

    do_move(1'b1, 1'b0, 1'b0, 1'b0);                    // wall above (1,1)
    do_move(1'b0, 1'b1, 1'b0, 1'b0);                    // key at (1,2)
    do_move(1'b1, 1'b0, 1'b0, 1'b0);
    do_move(1'b0, 1'b0, 1'b0, 1'b1);                    // ground at (2,1)
    repeat (13) do_move(1'b0, 1'b0, 1'b0, 1'b1);        // row of keys up to 14
    do_move(1'b0, 1'b1, 1'b0, 1'b0);                    // key 15
    do_move(1'b0, 1'b1, 1'b0, 1'b0);                    // saturated pickup
    do_move(1'b0, 1'b0, 1'b0, 1'b1);                    // off the right edge
    do_move(1'b1, 1'b0, 1'b1, 1'b0);                    // up wins over left

    // Reset mid-WAIT with a request held high through the move.
    for (int l = 0; l < 2; l++) begin
      s_re[l] = re_cnt[l]; s_we[l] = we_cnt[l]; s_done[l] = done_cnt[l];
    end
    req_left = 1'b1;
    tick();
    tick();
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("L%0d_abort_busy", l), 32'(busy_v[l]), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("L%0d_abort_busy_low", l), 32'(busy_v[l]), 32'd0);
      check_eq($sformatf("L%0d_abort_pos", l), 32'({py_v[l], px_v[l]}), 32'h11);
      check_eq($sformatf("L%0d_abort_key", l), 32'(key_v[l]), 32'd0);
      check_eq($sformatf("L%0d_abort_tgt", l), 32'(mt_posx_v[l]), 32'd0);
    end
    tick();
    req_left = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("L%0d_abort_re", l), re_cnt[l] - s_re[l], 32'd1);
      check_eq($sformatf("L%0d_abort_we", l), we_cnt[l] - s_we[l], 32'd0);
      check_eq($sformatf("L%0d_abort_done", l), done_cnt[l] - s_done[l], 32'd0);
    end
    m_px = 4'd1; m_py = 4'd1; m_key = 4'd0;

    do_move(1'b0, 1'b0, 1'b1, 1'b0);                    // to (0,1)
    do_move(1'b0, 1'b0, 1'b1, 1'b0);                    // off the left edge
    do_move(1'b0, 1'b0, 1'b0, 1'b0);                    // no request

    // Random map and random request patterns.
    for (int a = 0; a < 256; a++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: t = T_GROUND;
        4, 5:       t = T_WALL;
        6, 7:       t = T_KEY;
        8:          t = T_DOOR;
        default:    t = 16'(16'h0100 + $urandom_range(0, 255));
      endcase
      poke(addr_t'(a), t);
    end
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 15);
      do_move(r[0], r[1], r[2], r[3]);
    end

    check_eq("re_we_exclusive", excl[0] + excl[1], 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
